rx_uart_fifo: RTL and testbench
===============================

// Module: rx_uart_fifo
// PURPOSE
//  Receive-side byte FIFO between the UART bit deserializer and the SoC I/O read mux.
//  Buffers received bytes so console input survives CPU latency.
//  Presents the head byte show-ahead, so the mux samples it in the same cycle as the pop strobe.
//  Returns 32'hFFFF_FFFF when empty; the SoC derives "byte waiting" as !(&data).
// PARAMETERS
//  DEPTH      16  entries; power of two, >=2 (elaboration-time check)
//  IRQ_LEVEL  1   irq asserts when count >= IRQ_LEVEL; range 1..DEPTH
// PORTS
//  clk          in   1              system clock, all state on rising edge
//  resetn       in   1              asynchronous active-low reset
//  push         in   1              one-cycle strobe from deserializer: rx_byte valid
//  rx_byte      in   8              received byte
//  data_rd      in   1              pop strobe from SoC (uart_rx_ready), one cycle per read
//  data         out  32             empty ? 32'hFFFF_FFFF : {24'b0, head byte}
//  count        out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  empty        out  1              count == 0
//  full         out  1              count == DEPTH
//  overrun      out  1              sticky: a byte was dropped because the FIFO was full
//  clr_overrun  in   1              one-cycle strobe, clears overrun
//  irq          out  1              count >= IRQ_LEVEL (level, not pulse)
// BEHAVIOUR
//  - Reset (async assert, released synchronously by the system):
//    wr_ptr=0, rd_ptr=0, count=0, overrun=0 -> data=FFFF_FFFF, empty=1, full=0, irq=0.
//    Storage array is not reset.
//  - Pointers are $clog2(DEPTH) bits wide and wrap naturally at DEPTH.
//    count is kept separately to distinguish full from empty.
//  - Outputs are combinational decodes of registered state. No output depends on push/data_rd in the same cycle.
//  - Push (push=1):
//    - not full: mem[wr_ptr]<=rx_byte; wr_ptr++; count++. Byte is visible on data the next cycle if the FIFO was empty.
//  - Pop (data_rd=1):
//    - not empty: rd_ptr++; count--. data changes the cycle after the edge.
//    - empty: ignored; no pointer change and no error.
//  - Simultaneous push and pop:
//    - 0<count<DEPTH: both happen; count unchanged.
//    - empty: push accepted, pop ignored; count -> 1.
//    - full: pop frees the slot first, push accepted; count stays DEPTH; no overrun.
//  - Overrun:
//    - push while full and no pop: byte dropped, all pointers unchanged, overrun<=1.
//    - Set has priority over clr_overrun in the same cycle.
//  - Latency: push to data visible = 1 cycle; pop to next head visible = 1 cycle.
//  - irq/full/empty track count with no extra delay; irq drops on the same edge that takes count below IRQ_LEVEL.
//  - Reset asserted mid-stream discards all contents immediately (asynchronous); no partial state survives.
// TESTING
//  1. Reset, then idle -> data=32'hFFFF_FFFF, empty=1, count=0, irq=0, overrun=0.
//  2. Push 8'h41, then 8'h42 -> next cycle data=32'h0000_0041, count=2.
//     Pop -> data=32'h42. Pop -> data=FFFF_FFFF, empty=1.
//  3. Push 16 bytes 0x00..0x0F (DEPTH=16) -> full=1. Push 0xAA -> overrun=1, count=16.
//     Pop 16 times -> data sequence 0x00..0x0F; 0xAA never appears.
//  4. Fill to full, then push 0x55 with data_rd in the same cycle -> overrun=0, count=16.
//     Last byte popped after draining is 0x55.
//  5. Empty FIFO, push 0x7E with data_rd in the same cycle -> count=1, data=0x7E.
//     Then set overrun and assert clr_overrun together with an overrun push -> overrun stays 1.
//     A lone clr_overrun then clears it.
//  6. Push 40 bytes with interleaved pops (pointer wrap >2x), IRQ_LEVEL=4 -> FIFO order is preserved.
//     irq is high exactly when count>=4. Async resetn pulse mid-stream -> data=FFFF_FFFF at once.

Source files
------------

// File: rtl/rx_uart_fifo.sv
// Receive-side byte FIFO between the UART deserializer and the SoC read mux.
// The head byte is shown ahead of the pop; all-ones is returned when empty.
module rx_uart_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned IRQ_LEVEL = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      push,
    input  logic [7:0]                rx_byte,
    input  logic                      data_rd,
    output logic [31:0]               data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic                      full,
    output logic                      overrun,
    input  logic                      clr_overrun,
    output logic                      irq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rx_uart_fifo: DEPTH must be a power of two >= 2");
    end
    if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
        $error("rx_uart_fifo: IRQ_LEVEL must be in 1..DEPTH");
    end

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop on a full FIFO frees the slot the same cycle's push lands in.
    always_comb begin
        do_pop  = data_rd && !empty;
        do_push = push && (!full || do_pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Setting wins over a same-cycle clear.
            if (push && !do_push) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_comb begin
        empty = (count == '0);
        full  = (count == CW'(DEPTH));
        irq   = (count >= CW'(IRQ_LEVEL));
        data  = empty ? 32'hFFFF_FFFF : {24'b0, mem[rd_ptr]};
    end

endmodule

// File: tb/tb_rx_uart_fifo.sv
// Self-checking bench for rx_uart_fifo: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_rx_uart_fifo;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned IRQ_LEVEL = 4;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          push = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          data_rd = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [31:0]   data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overrun;
    logic          irq;

    int vectors = 0;
    int miscompares = 0;

    byte unsigned q[$];
    bit           m_ov = 1'b0;

    rx_uart_fifo #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .push        (push),
        .rx_byte     (rx_byte),
        .data_rd     (data_rd),
        .data        (data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_data;
        exp_data = (q.size() == 0) ? 32'hFFFF_FFFF : {24'b0, q[0]};
        chk({tag, ".data"},    data,              exp_data);
        chk({tag, ".count"},   32'(count),        32'(q.size()));
        chk({tag, ".empty"},   32'(empty),        32'(q.size() == 0));
        chk({tag, ".full"},    32'(full),         32'(q.size() == DEPTH));
        chk({tag, ".overrun"}, 32'(overrun),      32'(m_ov));
        chk({tag, ".irq"},     32'(irq),          32'(q.size() >= IRQ_LEVEL));
    endtask

    // One clock of stimulus; the model applies the FIFO rules at the edge.
    task automatic step(input bit p, input logic [7:0] b, input bit rd, input bit clr,
                        input string tag);
        bit pop_ok;
        bit push_ok;
        push = p; rx_byte = b; data_rd = rd; clr_overrun = clr;
        @(posedge clk);
        pop_ok  = rd && (q.size() > 0);
        push_ok = p && ((q.size() < DEPTH) || pop_ok);
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(b);
        if (p && !push_ok) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        #1;
        push = 1'b0; data_rd = 1'b0; clr_overrun = 1'b0;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] last;
        int pushed;
        int iters;

        // 1. reset and idle
        @(posedge clk); #1;
        check_all("rst");
        chk("t1_data", data, 32'hFFFF_FFFF);
        resetn = 1'b1;
        step(0, 8'h00, 0, 0, "t1_idle");
        step(0, 8'h00, 0, 0, "t1_idle");

        // 2. two bytes in, two out
        step(1, 8'h41, 0, 0, "t2_push");
        chk("t2_first_visible", data, 32'h0000_0041);
        step(1, 8'h42, 0, 0, "t2_push");
        chk("t2_head", data, 32'h0000_0041);
        chk("t2_count", 32'(count), 32'd2);
        step(0, 8'h00, 1, 0, "t2_pop");
        chk("t2_next", data, 32'h0000_0042);
        step(0, 8'h00, 1, 0, "t2_pop");
        chk("t2_drained", data, 32'hFFFF_FFFF);
        chk("t2_empty", 32'(empty), 32'd1);

        // 3. fill, overflow, drain in order
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, "t3_fill");
        chk("t3_full", 32'(full), 32'd1);
        step(1, 8'hAA, 0, 0, "t3_ovf");
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", data, 32'(i));
            step(0, 8'h00, 1, 0, "t3_drain");
        end
        chk("t3_empty", data, 32'hFFFF_FFFF);
        step(0, 8'h00, 0, 1, "t3_clr");

        // 4. push+pop on full: no overrun, new byte is last out
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, "t4_fill");
        step(1, 8'h55, 1, 0, "t4_both");
        chk("t4_overrun", 32'(overrun), 32'd0);
        chk("t4_count", 32'(count), 32'd16);
        last = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            last = data;
            step(0, 8'h00, 1, 0, "t4_drain");
        end
        chk("t4_last", last, 32'h0000_0055);

        // 5. push+pop on empty, then overrun set/clear priority
        step(1, 8'h7E, 1, 0, "t5_both");
        chk("t5_count", 32'(count), 32'd1);
        chk("t5_data", data, 32'h0000_007E);
        for (int i = 0; i < 15; i++) step(1, 8'(8'h60 + i), 0, 0, "t5_fill");
        step(1, 8'h99, 0, 0, "t5_ovf");
        step(1, 8'h98, 0, 1, "t5_set_vs_clr");
        chk("t5_set_wins", 32'(overrun), 32'd1);
        step(0, 8'h00, 0, 1, "t5_clr");
        chk("t5_cleared", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, "t5_drain");

        // 6. random traffic with pointer wrap, then async reset mid-stream
        pushed = 0;
        iters = 0;
        while (pushed < 40 && iters < 1000) begin
            bit p;
            bit rd;
            p  = ($urandom % 4) != 0;
            rd = ($urandom % 2) != 0;
            step(p, 8'($urandom), rd, 0, "t6_rand");
            if (p) pushed++;
            iters++;
        end
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0, "t6_top");
        @(negedge clk);
        resetn = 1'b0;
        #1;
        q.delete();
        m_ov = 1'b0;
        check_all("t6_async_rst");
        chk("t6_rst_data", data, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        resetn = 1'b1;
        step(0, 8'h00, 0, 0, "t6_after_rst");
        step(1, 8'h33, 0, 0, "t6_post_push");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
